int_to_fpu: RTL and testbench
=============================

# int_to_fpu

Converts a 32-bit two's-complement integer into the team's custom 32-bit float format: sign[31], exponent[30:25] with bias 31, and mantissa[24:0] with a hidden leading 1. It sits upstream of the `fpu` adder and produces its `op_A_in`/`op_B_in` operands. It is a multi-cycle FSM with a start/done handshake, iterative normalisation and round-to-nearest on the guard bit. Status reporting uses the same one-hot encoding as `fpu`.

## Interface
Parameters:
- `BIAS`, default 31: exponent bias; the encoded value is (-1)^s × 1.mant × 2^(exp−BIAS).

Ports:
- `clock100KHz`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request conversion of `int_in`; sampled only in IDLE.
- `int_in`  in  32  signed operand; latched on the edge that accepts `start`.
- `data_out`  out  32  encoded float {sign, exp[5:0], mant[24:0]}.
- `status_out`  out  4  EXACT=0001, INEXACT=0010, OVERFLOW=0100, UNDERFLOW=1000.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `data_out`/`status_out` are updated.

## Operation
- Reset (`reset`=0 at a rising edge), outputs: `data_out`=0, `status_out`=0000, `busy`=0, `done`=0. FSM goes to IDLE and all internal registers clear. Reset mid-conversion aborts it and produces no `done`.
- States: IDLE → ABS → NORM → ROUND → PACK → IDLE.
  - IDLE: on `start`=1, latch `int_in` and go to ABS.
  - ABS:
    - sign = bit 31; mag = |int_in| as a 32-bit unsigned value (−2^31 gives 0x80000000).
    - mag==0: go directly to PACK with a zero result.
    - Otherwise set exp = BIAS+31 and go to NORM.
  - NORM: while mag[31]==0, shift mag left by 1 and decrement exp, one shift per cycle. When mag[31]==1, go to ROUND.
  - ROUND:
    - mant = mag[30:6], guard = mag[5], sticky = |mag[4:0].
    - INEXACT is set when guard|sticky; round up (mant+1) when guard=1. Ties round away from zero.
    - If the increment carries out of 25 bits, mant becomes 0 and exp increments by 1.
  - PACK: register `data_out` = {sign, exp, mant}, or 32'h0 for zero input. Register `status_out`, pulse `done`, return to IDLE.
- Status:
  - INEXACT if rounding discarded nonzero bits, otherwise EXACT.
  - OVERFLOW and UNDERFLOW are never raised: the exponent range 31..62 always fits.
  - Zero input reports EXACT.
- `start` is ignored while `busy`=1. `int_in` may change freely after acceptance.
- `data_out`/`status_out` hold their values until the next PACK.

## Timing
- Let k = number of leading zeros of mag (0..31). The accepting edge is E0.
- Nonzero input:
  - ABS is E0→E1, NORM is E1→E(k+2), ROUND is E(k+2)→E(k+3).
  - PACK updates the outputs at E(k+4); `done`=1 for the cycle after E(k+4).
- Zero input: the outputs update at E2.
- Worst-case latency is 35 edges (int 1 or −1); best case is 4 edges (−2^31).
- `busy` rises after E0 and falls together with the `done` pulse. `start` may be re-asserted in the cycle `done` is high and is accepted at the next edge (back-to-back operation).

## Structure
- Shared package `fpu_pkg`, used by both `fpu` and this block, holds:
  - the status enum (EXACT/INEXACT/OVERFLOW/UNDERFLOW);
  - field-width constants (EXP_W=6, MANT_W=25);
  - the BIAS default.
- The state enum stays local to the module.
- Single module, no sub-modules: the iterative shifter replaces a priority encoder.

## Test plan
- Integers 1 / −1 → `data_out` 0x3E000000 / 0xBE000000, EXACT; `done` 35 edges after start.
- Integers 3 and 0x02000001 → 0x41000000 and 0x70000001, both EXACT.
- Integer 0x04000001 (guard set) → 0x72000001, INEXACT. Integer 0x7FFFFFFF → mantissa carry gives 0x7C000000, INEXACT.
- Integers 0 and 0x80000000 → 32'h0 (EXACT, latency 2) and 0xFC000000 (EXACT, latency 4).
- `start` pulsed while busy → ignored and result unchanged. Reset asserted mid-NORM → no `done` pulse, outputs 0, `busy`=0, and the next conversion is correct.
- Back-to-back: `start` held high continuously → one `done` per conversion with no lost or duplicated results. Compare every `data_out` against a bench model for 1000 random integers.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the custom 32-bit float datapath.
// Status encoding, field widths and default exponent bias.
package fpu_pkg;

  localparam int EXP_W    = 6;
  localparam int MANT_W   = 25;
  localparam int BIAS_DEF = 31;

  typedef enum logic [3:0] {
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } status_e;

endpackage

// File: rtl/int_to_fpu.sv
// Iterative int32 -> custom float converter with start/done handshake.
// Normalises one bit per cycle, rounds to nearest on the guard bit.
module int_to_fpu
  import fpu_pkg::*;
#(
  parameter int BIAS = BIAS_DEF
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_ROUND,
    S_PACK
  } state_e;

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + 31);

  state_e r_state;
  state_e w_next;

  logic [31:0]       r_mag;
  logic              r_sign;
  logic              r_zero;
  logic              r_inexact;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant;
  logic [31:0]       r_data;
  logic [3:0]        r_status;
  logic              r_done;

  logic [31:0]     w_abs;
  logic            w_guard;
  logic            w_sticky;
  logic [MANT_W:0] w_inc;

  assign w_abs    = r_mag[31] ? (~r_mag + 32'd1) : r_mag;
  assign w_guard  = r_mag[5];
  assign w_sticky = |r_mag[4:0];
  assign w_inc    = {1'b0, r_mag[30:6]} + {{MANT_W{1'b0}}, 1'b1};

  always_ff @(posedge clock100KHz) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ABS;
      S_ABS:   w_next = (r_mag == 32'd0) ? S_PACK : S_NORM;
      S_NORM:  if (r_mag[31]) w_next = S_ROUND;
      S_ROUND: w_next = S_PACK;
      S_PACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_inexact <= 1'b0;
      r_exp     <= '0;
      r_mant    <= '0;
      r_data    <= '0;
      r_status  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag  <= int_in;
            r_sign <= int_in[31];
          end
        end
        S_ABS: begin
          r_mag     <= w_abs;
          r_zero    <= (r_mag == 32'd0);
          r_exp     <= EXP_TOP;
          r_inexact <= 1'b0;
        end
        S_NORM: begin
          if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - EXP_W'(1);
          end
        end
        S_ROUND: begin
          r_inexact <= w_guard | w_sticky;
          // Carry out of the mantissa wraps it to zero and bumps the exponent
          if (w_guard) begin
            r_mant <= w_inc[MANT_W-1:0];
            if (w_inc[MANT_W]) r_exp <= r_exp + EXP_W'(1);
          end else begin
            r_mant <= r_mag[30:6];
          end
        end
        S_PACK: begin
          r_data   <= r_zero ? 32'd0 : {r_sign, r_exp, r_mant};
          r_status <= r_inexact ? ST_INEXACT : ST_EXACT;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_out   = r_data;
  assign status_out = r_status;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_int_to_fpu.sv
// Directed and random checks for int_to_fpu.
// Reference model rounds via integer remainder comparison.
module tb_int_to_fpu;

  localparam int BIAS = 31;
  localparam int NRND = 1000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] int_in;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  int_to_fpu #(.BIAS(BIAS)) dut (
    .clock100KHz(clk),
    .reset      (rst_n),
    .start      (start),
    .int_in     (int_in),
    .data_out   (data_out),
    .status_out (status_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] x);
    logic        s;
    logic [31:0] m;
    logic [31:0] rem;
    logic [31:0] half;
    logic [26:0] mf;
    logic        inx;
    int          p;
    int          sh;
    int          e;
    if (x == 32'd0) return {4'b0001, 32'd0};
    s = x[31];
    m = s ? (32'd0 - x) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e   = BIAS + p;
    inx = 1'b0;
    if (p <= 25) begin
      mf = 27'(m << (25 - p));
    end else begin
      sh   = p - 25;
      mf   = 27'(m >> sh);
      rem  = m & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      inx  = (rem != 32'd0);
      if (rem >= half) mf = mf + 27'd1;
      if (mf[26]) begin
        e  = e + 1;
        mf = '0;
      end
    end
    return {inx ? 4'b0010 : 4'b0001, s, 6'(e), mf[24:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] x);
    logic [31:0] m;
    int          k;
    if (x == 32'd0) return 2;
    m = x[31] ? (32'd0 - x) : x;
    k = 0;
    while (!m[31]) begin
      m = m << 1;
      k++;
    end
    return k + 4;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that raised done.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic convert(input logic [31:0] x, output int lat);
    start  = 1'b1;
    int_in = x;
    @(posedge clk);
    #1;
    start  = 1'b0;
    int_in = $urandom;
    wait_done(lat);
  endtask

  logic [31:0] vx   [8];
  logic [31:0] vd   [8];
  logic [3:0]  vs   [8];
  int          vl   [8];
  logic [31:0] rnd  [NRND];

  initial begin
    int          lat;
    int          cnt;
    logic [35:0] m;

    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    int_in = 32'hDEAD_BEEF;

    vx[0] = 32'h0000_0001; vd[0] = 32'h3E00_0000; vs[0] = 4'b0001; vl[0] = 35;
    vx[1] = 32'hFFFF_FFFF; vd[1] = 32'hBE00_0000; vs[1] = 4'b0001; vl[1] = 35;
    vx[2] = 32'h0000_0003; vd[2] = 32'h4100_0000; vs[2] = 4'b0001; vl[2] = 34;
    vx[3] = 32'h0200_0001; vd[3] = 32'h7000_0001; vs[3] = 4'b0001; vl[3] = 10;
    vx[4] = 32'h0400_0001; vd[4] = 32'h7200_0001; vs[4] = 4'b0010; vl[4] = 9;
    vx[5] = 32'h7FFF_FFFF; vd[5] = 32'h7C00_0000; vs[5] = 4'b0010; vl[5] = 5;
    vx[6] = 32'h0000_0000; vd[6] = 32'h0000_0000; vs[6] = 4'b0001; vl[6] = 2;
    vx[7] = 32'h8000_0000; vd[7] = 32'hFC00_0000; vs[7] = 4'b0001; vl[7] = 4;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      convert(vx[i], lat);
      chk($sformatf("dir%0d_data", i), data_out, vd[i]);
      chk($sformatf("dir%0d_status", i), {28'd0, status_out}, {28'd0, vs[i]});
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(vl[i]));
      chk($sformatf("dir%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // start pulsed mid-conversion must be ignored
    start  = 1'b1;
    int_in = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start  = 1'b1;
    int_in = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("busy_ign_data", data_out, 32'h3E00_0000);
    chk("busy_ign_lat", 32'(lat + 6), 32'd35);
    @(posedge clk);
    #1;
    chk("busy_ign_idle", {31'd0, busy}, 32'd0);

    // reset mid-normalisation aborts without a done pulse
    start  = 1'b1;
    int_in = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", {28'd0, status_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    chk("abort_nodone", 32'(cnt), 32'd0);
    convert(32'd3, lat);
    chk("post_abort_data", data_out, 32'h4100_0000);
    chk("post_abort_lat", 32'(lat), 32'd34);

    // back-to-back with start held high
    for (int i = 0; i < NRND; i++) begin
      rnd[i] = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rnd[i] = 32'd0 - rnd[i];
    end
    rnd[10] = 32'd0;
    rnd[11] = 32'h8000_0000;
    rnd[12] = 32'h7FFF_FFFF;
    start  = 1'b1;
    int_in = rnd[0];
    for (int i = 0; i < NRND; i++) begin
      @(posedge clk);
      #1;
      int_in = (i + 1 < NRND) ? rnd[i+1] : 32'd0;
      if (i + 1 == NRND) start = 1'b0;
      wait_done(lat);
      m = model(rnd[i]);
      chk($sformatf("rnd%0d_data x=%h", i, rnd[i]), data_out, m[31:0]);
      chk($sformatf("rnd%0d_status", i), {28'd0, status_out}, {28'd0, m[35:32]});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(model_lat(rnd[i])));
    end
    @(posedge clk);
    #1;
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
